// File: rtl/fb_pixel_if.sv
// fb_pixel_if: pixel handshake between the rasteriser core (master) and the frame-buffer writer (slave).
interface fb_pixel_if #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 16
);
    logic               data_ready;
    logic [ADDR_W-1:0]  address;
    logic [COLOR_W-1:0] color;
    logic               frame_target;
    logic               shape_done;
    logic               data_sent;
    logic               shape_committed;
    modport master (
        output data_ready, address, color, frame_target, shape_done,
        input  data_sent, shape_committed
    );
    modport slave (
        input  data_ready, address, color, frame_target, shape_done,
        output data_sent, shape_committed
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: accepts pixels from the core, bounds-checks them and commits each to
// frame-buffer SRAM with a fixed-length write strobe, reporting shape completion upstream.
module fb_pixel_writer #(
    parameter int ADDR_W    = 19,
    parameter int COLOR_W   = 16,
    parameter int FB_PIXELS = 307200,
    parameter int WR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    fb_pixel_if.slave          px,
    output logic               sram_wr_en,
    output logic [ADDR_W:0]    sram_addr,
    output logic [COLOR_W-1:0] sram_data,
    output logic               err_oob,
    output logic [19:0]        pixel_count
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_e;
    localparam logic [3:0] CNT_INIT = 4'(WR_CYCLES - 1);
    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               sram_wr_en_q, sram_wr_en_d;
    logic [ADDR_W:0]    sram_addr_q, sram_addr_d;
    logic [COLOR_W-1:0] sram_data_q, sram_data_d;
    logic               data_sent_q, data_sent_d;
    logic               shape_committed_q, shape_committed_d;
    logic               pending_q, pending_d;
    logic               err_oob_q, err_oob_d;
    logic [19:0]        pixel_count_q, pixel_count_d;
    logic               in_range;
    assign in_range = 32'(px.address) < FB_PIXELS;
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        sram_wr_en_d      = sram_wr_en_q;
        sram_addr_d       = sram_addr_q;
        sram_data_d       = sram_data_q;
        data_sent_d       = 1'b0;
        shape_committed_d = 1'b0;
        pending_d         = pending_q | px.shape_done;
        err_oob_d         = err_oob_q;
        pixel_count_d     = pixel_count_q;
        case (state_q)
            IDLE: begin
                if (px.data_ready) begin
                    sram_addr_d  = {px.frame_target, px.address};
                    sram_data_d  = px.color;
                    cnt_d        = CNT_INIT;
                    sram_wr_en_d = in_range;
                    data_sent_d  = !in_range;
                    err_oob_d    = err_oob_q | !in_range;
                    state_d      = in_range ? WRITE : ACK;
                end else if (pending_q) begin
                    // a shape_done arriving now merges into this commit
                    shape_committed_d = 1'b1;
                    pending_d         = 1'b0;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    sram_wr_en_d  = 1'b0;
                    data_sent_d   = 1'b1;
                    pixel_count_d = pixel_count_q + {19'd0, ~&pixel_count_q};
                    state_d       = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            sram_wr_en_q      <= 1'b0;
            sram_addr_q       <= '0;
            sram_data_q       <= '0;
            data_sent_q       <= 1'b0;
            shape_committed_q <= 1'b0;
            pending_q         <= 1'b0;
            err_oob_q         <= 1'b0;
            pixel_count_q     <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            sram_wr_en_q      <= sram_wr_en_d;
            sram_addr_q       <= sram_addr_d;
            sram_data_q       <= sram_data_d;
            data_sent_q       <= data_sent_d;
            shape_committed_q <= shape_committed_d;
            pending_q         <= pending_d;
            err_oob_q         <= err_oob_d;
            pixel_count_q     <= pixel_count_d;
        end
    end
    assign sram_wr_en         = sram_wr_en_q;
    assign sram_addr          = sram_addr_q;
    assign sram_data          = sram_data_q;
    assign px.data_sent       = data_sent_q;
    assign px.shape_committed = shape_committed_q;
    assign err_oob            = err_oob_q;
    assign pixel_count        = pixel_count_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed pixels pushed into a scoreboard; a negedge monitor checks
// every strobe, data_sent and shape_committed against the queued expectations.
module tb_fb_pixel_writer;
    localparam int WR = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_wr_en;
    logic [19:0] sram_addr;
    logic [15:0] sram_data;
    logic        err_oob;
    logic [19:0] pixel_count;
    always #5 clk = ~clk;
    fb_pixel_if #(.ADDR_W(19), .COLOR_W(16)) px ();
    fb_pixel_writer #(.ADDR_W(19), .COLOR_W(16), .FB_PIXELS(307200), .WR_CYCLES(WR)) dut (
        .clk(clk), .rst(rst), .px(px), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
        .sram_data(sram_data), .err_oob(err_oob), .pixel_count(pixel_count)
    );
    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
        bit          wr;
        int          cap;
    } exp_t;
    exp_t expq[$];
    int   scq[$];
    int   sent_cyc[$];
    exp_t e_m;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            scq.delete();
            strobes = 0;
        end else begin
            if (sram_wr_en) begin
                strobes++;
                chk("write_expected", expq.size(), 1);
                if (expq.size() != 0) begin
                    chk("wr_addr", 32'(sram_addr), 32'(expq[0].addr));
                    chk("wr_data", 32'(sram_data), 32'(expq[0].data));
                end
            end
            if (px.data_sent) begin
                chk("sent_expected", expq.size(), 1);
                if (expq.size() != 0) begin
                    e_m = expq.pop_front();
                    chk("sent_latency", cyc - e_m.cap + 1, e_m.wr ? WR + 1 : 1);
                    chk("strobe_count", strobes, e_m.wr ? WR : 0);
                    chk("sent_addr", 32'(sram_addr), 32'(e_m.addr));
                    chk("sent_data", 32'(sram_data), 32'(e_m.data));
                    chk("wr_in_ack", 32'(sram_wr_en), 0);
                    sent_cyc.push_back(cyc);
                end
                strobes = 0;
            end
            if (px.shape_committed) begin
                chk("commit_expected", scq.size(), 1);
                if (scq.size() != 0) chk("commit_cycle", cyc, scq.pop_front());
                chk("commit_during_write", 32'(sram_wr_en), 0);
            end
        end
    end
    // called just after a rising edge with the writer idle; returns just after the ACK edge
    task automatic send(input logic [18:0] a, input logic [15:0] c, input logic ft);
        bit wr = 32'(a) < 307200;
        px.data_ready   = 1'b1;
        px.address      = a;
        px.color        = c;
        px.frame_target = ft;
        expq.push_back('{addr: {ft, a}, data: c, wr: wr, cap: cyc + 1});
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (px.data_sent) break;
            if (n == 1) px.frame_target = ~ft;
        end
        chk("sent_timeout", 32'(px.data_sent), 1);
        @(posedge clk);
        #1;
        px.data_ready = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
    initial begin
        px.data_ready   = 1'b0;
        px.address      = '0;
        px.color        = '0;
        px.frame_target = 1'b0;
        px.shape_done   = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_wr_en", 32'(sram_wr_en), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_data", 32'(sram_data), 0);
        chk("rst_sent", 32'(px.data_sent), 0);
        chk("rst_commit", 32'(px.shape_committed), 0);
        chk("rst_err", 32'(err_oob), 0);
        chk("rst_count", 32'(pixel_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        send(19'd640, 16'h0060, 1'b1);
        chk("t1_addr", 32'(sram_addr), 32'h80280);
        chk("t1_data", 32'(sram_data), 32'h0060);
        chk("t1_count", 32'(pixel_count), 1);
        sent_cyc.delete();
        send(19'd0, 16'hFFFF, 1'b0);
        send(19'd1, 16'h1234, 1'b1);
        send(19'd479, 16'hA5A5, 1'b0);
        chk("stream_sent_n", sent_cyc.size(), 3);
        if (sent_cyc.size() == 3) begin
            chk("stream_gap0", sent_cyc[1] - sent_cyc[0], 4);
            chk("stream_gap1", sent_cyc[2] - sent_cyc[1], 4);
        end
        chk("stream_count", 32'(pixel_count), 4);
        idle(2);
        send(19'd307200, 16'hF800, 1'b0);
        chk("oob_err", 32'(err_oob), 1);
        chk("oob_count", 32'(pixel_count), 4);
        send(19'd307199, 16'h07E0, 1'b1);
        chk("edge_err_sticky", 32'(err_oob), 1);
        chk("edge_count", 32'(pixel_count), 5);
        send(19'd524287, 16'h001F, 1'b1);
        chk("oob_max_count", 32'(pixel_count), 5);
        idle(3);
        send(19'd100, 16'h0101, 1'b0);
        fork
            send(19'd101, 16'h0202, 1'b0);
            begin
                @(posedge clk); #1; px.shape_done = 1'b1;
                @(posedge clk); #1; px.shape_done = 1'b0;
            end
        join
        scq.push_back(cyc + 1);
        idle(5);
        chk("shape1_pending", scq.size(), 0);
        fork
            send(19'd200, 16'h0303, 1'b1);
            begin
                @(posedge clk); #1; px.shape_done = 1'b1;
                @(posedge clk); #1; px.shape_done = 1'b0;
                @(posedge clk); #1; px.shape_done = 1'b1;
                @(posedge clk); #1; px.shape_done = 1'b0;
            end
        join
        scq.push_back(cyc + 1);
        idle(6);
        chk("shape2_pending", scq.size(), 0);
        px.shape_done = 1'b1;
        scq.push_back(cyc + 2);
        idle(1);
        px.shape_done = 1'b0;
        idle(5);
        chk("shape3_pending", scq.size(), 0);
        px.data_ready   = 1'b1;
        px.address      = 19'd7;
        px.color        = 16'hBEEF;
        px.frame_target = 1'b1;
        expq.push_back('{addr: {1'b1, 19'd7}, data: 16'hBEEF, wr: 1'b1, cap: cyc + 1});
        idle(2);
        rst = 1'b1;
        px.data_ready = 1'b0;
        idle(1);
        chk("mid_rst_wr_en", 32'(sram_wr_en), 0);
        chk("mid_rst_sent", 32'(px.data_sent), 0);
        chk("mid_rst_addr", 32'(sram_addr), 0);
        chk("mid_rst_data", 32'(sram_data), 0);
        chk("mid_rst_err", 32'(err_oob), 0);
        chk("mid_rst_count", 32'(pixel_count), 0);
        rst = 1'b0;
        idle(5);
        send(19'd12345, 16'h5A5A, 1'b0);
        chk("post_rst_count", 32'(pixel_count), 1);
        idle(4);
        chk("final_expq", expq.size(), 0);
        chk("final_scq", scq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
